// File: rtl/reg_si_master.sv
// Register-bus master: assembles fixed-length host frames (address byte, then data bytes LSB first)
// into single-cycle writes on the register simple interface, discarding stalled partial frames.
module reg_si_master #(
    parameter int REG_DATA_WIDTH = 16,
    parameter int REG_ADDR_WIDTH = 8,
    parameter int TIMEOUT_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                      clk_i,
    input  logic                      rst,
    input  logic [7:0]                rx_data_i,
    input  logic                      rx_rdy_i,
    output logic [REG_DATA_WIDTH-1:0] reg_si_data,
    output logic [REG_ADDR_WIDTH-1:0] reg_si_addr,
    output logic                      reg_si_rdy,
    output logic                      busy_o,
    output logic                      frame_err_o
);

    localparam int DATA_BYTES = REG_DATA_WIDTH / 8;
    localparam int IDX_W      = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] EXPIRY =
        (TIMEOUT_CYCLES > 0) ? TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic {IDLE, DATA} state_t;

    state_t                    state, state_n;
    logic [IDX_W-1:0]          idx, idx_n;
    logic [TIMEOUT_WIDTH-1:0]  tcnt, tcnt_n;
    logic [REG_ADDR_WIDTH-1:0] addr_sh, addr_sh_n;
    logic [REG_DATA_WIDTH-1:0] data_sh, data_sh_n;
    logic [REG_DATA_WIDTH-1:0] data_n;
    logic [REG_ADDR_WIDTH-1:0] addr_n;
    logic                      rdy_n, err_n;

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            tcnt        <= '0;
            addr_sh     <= '0;
            data_sh     <= '0;
            reg_si_data <= '0;
            reg_si_addr <= '0;
            reg_si_rdy  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            tcnt        <= tcnt_n;
            addr_sh     <= addr_sh_n;
            data_sh     <= data_sh_n;
            reg_si_data <= data_n;
            reg_si_addr <= addr_n;
            reg_si_rdy  <= rdy_n;
            frame_err_o <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        tcnt_n    = tcnt;
        addr_sh_n = addr_sh;
        data_sh_n = data_sh;
        data_n    = reg_si_data;
        addr_n    = reg_si_addr;
        rdy_n     = 1'b0;
        err_n     = 1'b0;
        case (state)
            IDLE: begin
                if (rx_rdy_i) begin
                    addr_sh_n = rx_data_i[REG_ADDR_WIDTH-1:0];
                    idx_n     = '0;
                    tcnt_n    = '0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                // An incoming byte takes priority over timeout expiry in the same cycle.
                if (rx_rdy_i) begin
                    tcnt_n = '0;
                    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
                        if (idx == IDX_W'(i)) data_sh_n[8*i +: 8] = rx_data_i;
                    end
                    if (idx == LAST_IDX) begin
                        addr_n  = addr_sh;
                        data_n  = data_sh_n;
                        rdy_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (tcnt == EXPIRY) begin
                        state_n   = IDLE;
                        err_n     = 1'b1;
                        addr_sh_n = '0;
                        data_sh_n = '0;
                        idx_n     = '0;
                        tcnt_n    = '0;
                    end else if (tcnt != '1) begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy_o = (state == DATA);

endmodule

// File: tb/tb_reg_si_master.sv
// Directed self-checking bench for reg_si_master: four instances cover defaults,
// a short timeout, a wide data/narrow address variant and a disabled timeout.
module tb_reg_si_master;

    logic clk = 1'b0;
    logic rst;
    logic [7:0] rxd [4];
    logic       rxr [4];

    logic [15:0] data0, data1, data3;
    logic [31:0] data2;
    logic [7:0]  addr0, addr1, addr3;
    logic [3:0]  addr2;
    logic        rdy0, rdy1, rdy2, rdy3;
    logic        busy0, busy1, busy2, busy3;
    logic        err0, err1, err2, err3;

    int n_checks = 0;
    int n_fail   = 0;
    int rdyc [4] = '{0, 0, 0, 0};
    int errc [4] = '{0, 0, 0, 0};
    int both     = 0;

    always #5 clk = ~clk;

    reg_si_master u0 (.clk_i(clk), .rst(rst), .rx_data_i(rxd[0]), .rx_rdy_i(rxr[0]),
        .reg_si_data(data0), .reg_si_addr(addr0), .reg_si_rdy(rdy0), .busy_o(busy0), .frame_err_o(err0));
    reg_si_master #(.TIMEOUT_CYCLES(10)) u1 (.clk_i(clk), .rst(rst), .rx_data_i(rxd[1]), .rx_rdy_i(rxr[1]),
        .reg_si_data(data1), .reg_si_addr(addr1), .reg_si_rdy(rdy1), .busy_o(busy1), .frame_err_o(err1));
    reg_si_master #(.REG_DATA_WIDTH(32), .REG_ADDR_WIDTH(4)) u2 (.clk_i(clk), .rst(rst), .rx_data_i(rxd[2]),
        .rx_rdy_i(rxr[2]), .reg_si_data(data2), .reg_si_addr(addr2), .reg_si_rdy(rdy2), .busy_o(busy2),
        .frame_err_o(err2));
    reg_si_master #(.TIMEOUT_CYCLES(0)) u3 (.clk_i(clk), .rst(rst), .rx_data_i(rxd[3]), .rx_rdy_i(rxr[3]),
        .reg_si_data(data3), .reg_si_addr(addr3), .reg_si_rdy(rdy3), .busy_o(busy3), .frame_err_o(err3));

    always @(negedge clk) begin
        if (rdy0) rdyc[0]++;
        if (rdy1) rdyc[1]++;
        if (rdy2) rdyc[2]++;
        if (rdy3) rdyc[3]++;
        if (err0) errc[0]++;
        if (err1) errc[1]++;
        if (err2) errc[2]++;
        if (err3) errc[3]++;
        if ((rdy0 && err0) || (rdy1 && err1) || (rdy2 && err2) || (rdy3 && err3)) both++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int s, input logic [7:0] b);
        rxd[s] = b;
        rxr[s] = 1'b1;
        tick();
        rxr[s] = 1'b0;
        rxd[s] = 8'hxx;
    endtask

    task automatic test_reset();
        n_checks++; if (data0 !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", data0); end
        n_checks++; if (addr0 !== 8'h0) begin n_fail++; $display("FAIL reset_addr: got %0h expected 0", addr0); end
        n_checks++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %0b expected 0", rdy0); end
        n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy0); end
        n_checks++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b expected 0", err0); end
        n_checks++; if (data2 !== 32'h0) begin n_fail++; $display("FAIL reset_data_wide: got %0h expected 0", data2); end
    endtask

    task automatic test_single_write();
        send(0, 8'h02);
        n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %0b expected 1", busy0); end
        send(0, 8'h03);
        n_checks++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL single_early_rdy: got %0b expected 0", rdy0); end
        send(0, 8'h00);
        n_checks++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL single_rdy: got %0b expected 1", rdy0); end
        n_checks++; if (addr0 !== 8'h02) begin n_fail++; $display("FAIL single_addr: got %0h expected 02", addr0); end
        n_checks++; if (data0 !== 16'h0003) begin n_fail++; $display("FAIL single_data: got %0h expected 0003", data0); end
        n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %0b expected 0", busy0); end
        tick();
        n_checks++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL single_rdy_pulse: got %0b expected 0", rdy0); end
        n_checks++; if (data0 !== 16'h0003) begin n_fail++; $display("FAIL single_data_hold: got %0h expected 0003", data0); end
    endtask

    task automatic test_back_to_back();
        send(0, 8'h00); send(0, 8'h34); send(0, 8'h12);
        n_checks++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy1: got %0b expected 1", rdy0); end
        n_checks++; if ({addr0, data0} !== 24'h00_1234) begin n_fail++; $display("FAIL b2b_w1: got %0h expected 001234", {addr0, data0}); end
        send(0, 8'h01);
        n_checks++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL b2b_gap1: got %0b expected 0", rdy0); end
        send(0, 8'hCD);
        n_checks++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL b2b_gap2: got %0b expected 0", rdy0); end
        send(0, 8'hAB);
        n_checks++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy2: got %0b expected 1", rdy0); end
        n_checks++; if ({addr0, data0} !== 24'h01_ABCD) begin n_fail++; $display("FAIL b2b_w2: got %0h expected 01abcd", {addr0, data0}); end
        tick();
    endtask

    task automatic test_timeout();
        int r0;
        send(1, 8'h09); send(1, 8'hEF); send(1, 8'hBE);
        n_checks++; if ({addr1, data1} !== 24'h09_BEEF) begin n_fail++; $display("FAIL to_setup: got %0h expected 09beef", {addr1, data1}); end
        tick();
        r0 = rdyc[1];
        send(1, 8'h05); send(1, 8'h11);
        repeat (9) tick();
        n_checks++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL to_busy_before: got %0b expected 1", busy1); end
        n_checks++; if (err1 !== 1'b0) begin n_fail++; $display("FAIL to_err_early: got %0b expected 0", err1); end
        tick();
        n_checks++; if (err1 !== 1'b1) begin n_fail++; $display("FAIL to_err: got %0b expected 1", err1); end
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL to_busy_after: got %0b expected 0", busy1); end
        n_checks++; if ({addr1, data1} !== 24'h09_BEEF) begin n_fail++; $display("FAIL to_hold: got %0h expected 09beef", {addr1, data1}); end
        tick();
        n_checks++; if (err1 !== 1'b0) begin n_fail++; $display("FAIL to_err_pulse: got %0b expected 0", err1); end
        n_checks++; if (rdyc[1] !== r0) begin n_fail++; $display("FAIL to_no_write: got %0d expected %0d", rdyc[1], r0); end
        send(1, 8'h06); send(1, 8'h22); send(1, 8'h33);
        n_checks++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL to_next_rdy: got %0b expected 1", rdy1); end
        n_checks++; if ({addr1, data1} !== 24'h06_3322) begin n_fail++; $display("FAIL to_next_write: got %0h expected 063322", {addr1, data1}); end
        tick();
    endtask

    task automatic test_expiry_collision();
        int e0;
        e0 = errc[1];
        send(1, 8'h0A);
        repeat (9) tick();
        send(1, 8'h77);
        n_checks++; if (err1 !== 1'b0) begin n_fail++; $display("FAIL col_err: got %0b expected 0", err1); end
        n_checks++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL col_busy: got %0b expected 1", busy1); end
        repeat (9) tick();
        send(1, 8'h88);
        n_checks++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL col_rdy: got %0b expected 1", rdy1); end
        n_checks++; if ({addr1, data1} !== 24'h0A_8877) begin n_fail++; $display("FAIL col_write: got %0h expected 0a8877", {addr1, data1}); end
        n_checks++; if (errc[1] !== e0) begin n_fail++; $display("FAIL col_err_count: got %0d expected %0d", errc[1], e0); end
        tick();
    endtask

    task automatic test_async_reset();
        send(0, 8'h07); send(0, 8'h44);
        #3 rst = 1'b1;
        #1;
        n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL ar_busy: got %0b expected 0", busy0); end
        n_checks++; if ({addr0, data0} !== 24'h0) begin n_fail++; $display("FAIL ar_outputs: got %0h expected 0", {addr0, data0}); end
        n_checks++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL ar_rdy: got %0b expected 0", rdy0); end
        #2 rst = 1'b0;
        tick();
        send(0, 8'h08); send(0, 8'h55); send(0, 8'h66);
        n_checks++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL ar_next_rdy: got %0b expected 1", rdy0); end
        n_checks++; if ({addr0, data0} !== 24'h08_6655) begin n_fail++; $display("FAIL ar_next_write: got %0h expected 086655", {addr0, data0}); end
        tick();
    endtask

    task automatic test_wide();
        send(2, 8'hF3); send(2, 8'h01); send(2, 8'h02); send(2, 8'h03);
        n_checks++; if (rdy2 !== 1'b0) begin n_fail++; $display("FAIL wide_early_rdy: got %0b expected 0", rdy2); end
        send(2, 8'h04);
        n_checks++; if (rdy2 !== 1'b1) begin n_fail++; $display("FAIL wide_rdy: got %0b expected 1", rdy2); end
        n_checks++; if (addr2 !== 4'h3) begin n_fail++; $display("FAIL wide_addr: got %0h expected 3", addr2); end
        n_checks++; if (data2 !== 32'h0403_0201) begin n_fail++; $display("FAIL wide_data: got %0h expected 04030201", data2); end
        tick();
    endtask

    task automatic test_no_timeout();
        send(3, 8'h01); send(3, 8'h02);
        repeat (1000) tick();
        n_checks++; if (errc[3] !== 0) begin n_fail++; $display("FAIL nto_err: got %0d expected 0", errc[3]); end
        n_checks++; if (busy3 !== 1'b1) begin n_fail++; $display("FAIL nto_busy: got %0b expected 1", busy3); end
        send(3, 8'h03);
        n_checks++; if ({rdy3, addr3, data3} !== {1'b1, 24'h01_0302}) begin
            n_fail++; $display("FAIL nto_write: got %0h expected 1010302", {rdy3, addr3, data3});
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rxd[i] = 8'h00;
            rxr[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        tick();
        test_single_write();
        test_back_to_back();
        test_timeout();
        test_expiry_collision();
        test_async_reset();
        test_wide();
        test_no_timeout();
        n_checks++; if (both !== 0) begin n_fail++; $display("FAIL rdy_err_overlap: got %0d expected 0", both); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
